switch_input_ctrl: RTL and testbench

SWITCH_INPUT_CTRL -- requirements
Module: switch_input_ctrl

---
 rtl/switch_input_ctrl.sv | 107 ++++++++++
 tb/tb_switch_input_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/switch_input_ctrl.sv
// Debounced switch/button input block with a 4-register MMIO read port.
// Optional macro SWITCH_INPUT_IRQ_EN adds a registered irq = |press_latch.
module switch_input_ctrl #(
  parameter int unsigned SW_WIDTH        = 16,
  parameter int unsigned BTN_WIDTH       = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [BTN_WIDTH-1:0] btn_in,
  input  logic                 io_rd,
  input  logic [1:0]           io_addr,
  output logic [31:0]          io_rdata,
  output logic                 io_rvalid
`ifdef SWITCH_INPUT_IRQ_EN
  ,
  output logic                 irq
`endif
);

  localparam int unsigned N  = SW_WIDTH + BTN_WIDTH;
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]         sync1_q, sync2_q;
  logic [N-1:0]         stable_q, stable_d;
  logic [CW-1:0]        cnt_q [N];
  logic [CW-1:0]        cnt_d [N];
  logic [BTN_WIDTH-1:0] btn_prev_q;
  logic [BTN_WIDTH-1:0] latch_q, latch_d;
  logic [15:0]          count_q, count_d;
  logic [31:0]          rdata_d;

  logic [SW_WIDTH-1:0]  sw_stable;
  logic [BTN_WIDTH-1:0] btn_stable;
  logic [BTN_WIDTH-1:0] rise;
  logic                 rd_latch;

  assign sw_stable  = stable_q[SW_WIDTH-1:0];
  assign btn_stable = stable_q[N-1:SW_WIDTH];
  assign rise       = btn_stable & ~btn_prev_q;
  assign rd_latch   = io_rd && (io_addr == 2'd2);

  // Any return to the stable level before acceptance restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < N; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) stable_d[i] = sync2_q[i];
        else                     cnt_d[i]    = cnt_q[i] + CW'(1);
      end
    end
  end

  // A read of addr 2 returns all latch bits, so clearing all of them clears
  // exactly what was returned; a same-cycle rise is OR'd back in (set wins).
  always_comb begin
    latch_d = (rd_latch ? '0 : latch_q) | rise;
    count_d = count_q + {15'd0, |rise};
  end

  always_comb begin
    rdata_d = '0;
    if (io_rd) begin
      case (io_addr)
        2'd0:    rdata_d[SW_WIDTH-1:0]  = sw_stable;
        2'd1:    rdata_d[BTN_WIDTH-1:0] = btn_stable;
        2'd2:    rdata_d[BTN_WIDTH-1:0] = latch_q;
        default: rdata_d[15:0]          = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      stable_q   <= '0;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= '0;
      btn_prev_q <= '0;
      latch_q    <= '0;
      count_q    <= '0;
      io_rdata   <= '0;
      io_rvalid  <= 1'b0;
    end else begin
      sync1_q    <= {btn_in, sw_in};
      sync2_q    <= sync1_q;
      stable_q   <= stable_d;
      for (int unsigned i = 0; i < N; i++) cnt_q[i] <= cnt_d[i];
      btn_prev_q <= btn_stable;
      latch_q    <= latch_d;
      count_q    <= count_d;
      io_rdata   <= rdata_d;
      io_rvalid  <= io_rd;
    end
  end

`ifdef SWITCH_INPUT_IRQ_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) irq <= 1'b0;
    else      irq <= |latch_d;
  end
`endif

endmodule

// File: tb/tb_switch_input_ctrl.sv
// Directed bench for switch_input_ctrl with DEBOUNCE_CYCLES=4.
module tb_switch_input_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sw_in;
  logic [4:0]  btn_in;
  logic        io_rd;
  logic [1:0]  io_addr;
  logic [31:0] io_rdata;
  logic        io_rvalid;
`ifdef SWITCH_INPUT_IRQ_EN
  logic        irq;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  switch_input_ctrl #(
    .SW_WIDTH(16),
    .BTN_WIDTH(5),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .btn_in(btn_in),
    .io_rd(io_rd),
    .io_addr(io_addr),
    .io_rdata(io_rdata),
    .io_rvalid(io_rvalid)
`ifdef SWITCH_INPUT_IRQ_EN
    ,
    .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  // Issues one read; on return (next negedge) the response is on the outputs.
  task automatic do_read(input logic [1:0] a);
    @(negedge clk);
    io_rd   = 1'b1;
    io_addr = a;
    @(negedge clk);
    io_rd   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; sw_in = '0; btn_in = '0; io_rd = 1'b0; io_addr = '0;
    @(negedge clk);
    n_vec++;
    if (io_rvalid !== 1'b0 || io_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_outputs: rvalid=%b rdata=%h want 0/0", io_rvalid, io_rdata);
    end
`ifdef SWITCH_INPUT_IRQ_EN
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a));
      n_vec++;
      if (io_rvalid !== 1'b1 || io_rdata !== 32'h0) begin
        n_fail++; $display("FAIL reset_reg%0d: rvalid=%b rdata=%h want 1/00000000", a, io_rvalid, io_rdata);
      end
    end
    @(negedge clk);
    n_vec++;
    if (io_rvalid !== 1'b0 || io_rdata !== 32'h0) begin
      n_fail++; $display("FAIL idle_outputs: rvalid=%b rdata=%h want 0/0", io_rvalid, io_rdata);
    end
  endtask

  // Back-to-back addr 0 reads from the cycle sw_in changes: the read sampled
  // on the 7th edge is the first one to see the accepted value.
  task automatic test_switch();
    logic [31:0] exp;
    @(negedge clk);
    sw_in = 16'hA5A5; io_rd = 1'b1; io_addr = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 32'h0000A5A5 : 32'h0;
      n_vec++;
      if (io_rvalid !== 1'b1 || io_rdata !== exp) begin
        n_fail++; $display("FAIL switch_accept_k%0d: rvalid=%b rdata=%h want 1/%h", k, io_rvalid, io_rdata, exp);
      end
    end
    io_rd = 1'b0;
  endtask

  task automatic test_glitch();
    @(negedge clk); btn_in[2] = 1'b1;
    repeat (2) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    for (int a = 1; a < 4; a++) begin
      do_read(2'(a));
      n_vec++;
      if (io_rdata !== 32'h0) begin
        n_fail++; $display("FAIL glitch_reg%0d: got %h want 00000000", a, io_rdata);
      end
    end
  endtask

  task automatic test_press();
    @(negedge clk); btn_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    do_read(2'd1);
    n_vec++;
    if (io_rdata !== 32'h1) begin n_fail++; $display("FAIL press_btn_stable: got %h want 00000001", io_rdata); end
`ifdef SWITCH_INPUT_IRQ_EN
    n_vec++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL press_irq_set: got %b want 1", irq); end
`endif
    btn_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    do_read(2'd2);
    n_vec++;
    if (io_rdata !== 32'h1) begin n_fail++; $display("FAIL press_latch_first: got %h want 00000001", io_rdata); end
`ifdef SWITCH_INPUT_IRQ_EN
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL press_irq_clear: got %b want 0", irq); end
`endif
    do_read(2'd2);
    n_vec++;
    if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL press_latch_second: got %h want 00000000", io_rdata); end
    do_read(2'd3);
    n_vec++;
    if (io_rdata !== 32'h1) begin n_fail++; $display("FAIL press_count: got %h want 00000001", io_rdata); end
    do_read(2'd1);
    n_vec++;
    if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL release_btn_stable: got %h want 00000000", io_rdata); end
  endtask

  // Read of addr 2 lands in the exact cycle btn[1]'s rise is being latched.
  task automatic test_set_wins();
    @(negedge clk); btn_in[0] = 1'b1;
    repeat (10) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    btn_in[1] = 1'b1;
    repeat (6) @(negedge clk);
    io_rd = 1'b1; io_addr = 2'd2;
    @(negedge clk);
    io_rd = 1'b0;
    n_vec++;
    if (io_rvalid !== 1'b1 || io_rdata !== 32'h1) begin
      n_fail++; $display("FAIL setwins_read: rvalid=%b rdata=%h want 1/00000001", io_rvalid, io_rdata);
    end
    do_read(2'd2);
    n_vec++;
    if (io_rdata !== 32'h2) begin n_fail++; $display("FAIL setwins_after: got %h want 00000002", io_rdata); end
    do_read(2'd3);
    n_vec++;
    if (io_rdata !== 32'h3) begin n_fail++; $display("FAIL setwins_count: got %h want 00000003", io_rdata); end
    btn_in[1] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    @(negedge clk); btn_in[4:3] = 2'b11;
    repeat (10) @(negedge clk);
    btn_in[4:3] = 2'b00;
    repeat (8) @(negedge clk);
    do_read(2'd2);
    n_vec++;
    if (io_rdata !== 32'h18) begin n_fail++; $display("FAIL simul_latch: got %h want 00000018", io_rdata); end
    do_read(2'd3);
    n_vec++;
    if (io_rdata !== 32'h4) begin n_fail++; $display("FAIL simul_count: got %h want 00000004", io_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'h0000A5A5, 32'h4, 32'h4, 32'h5};
    @(negedge clk); btn_in[2] = 1'b1;
    repeat (10) @(negedge clk);
    io_rd = 1'b1; io_addr = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 3) io_addr = 2'(k + 1);
      else       io_rd = 1'b0;
      n_vec++;
      if (io_rvalid !== 1'b1 || io_rdata !== exp[k]) begin
        n_fail++; $display("FAIL b2b_addr%0d: rvalid=%b rdata=%h want 1/%h", k, io_rvalid, io_rdata, exp[k]);
      end
    end
    @(negedge clk);
    n_vec++;
    if (io_rvalid !== 1'b0 || io_rdata !== 32'h0) begin
      n_fail++; $display("FAIL b2b_tail: rvalid=%b rdata=%h want 0/0", io_rvalid, io_rdata);
    end
    btn_in[2] = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    @(negedge clk); sw_in = 16'hFFFF;
    repeat (3) @(negedge clk);
    io_rd = 1'b1; io_addr = 2'd3;
    @(posedge clk); #2;
    n_vec++;
    if (io_rvalid !== 1'b1 || io_rdata !== 32'h5) begin
      n_fail++; $display("FAIL pre_reset_read: rvalid=%b rdata=%h want 1/00000005", io_rvalid, io_rdata);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (io_rvalid !== 1'b0 || io_rdata !== 32'h0) begin
      n_fail++; $display("FAIL async_reset: rvalid=%b rdata=%h want 0/0", io_rvalid, io_rdata);
    end
`ifdef SWITCH_INPUT_IRQ_EN
    n_vec++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL async_reset_irq: got %b want 0", irq); end
`endif
    @(negedge clk); io_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1; io_rd = 1'b1; io_addr = 2'd0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp = (k >= 7) ? 32'h0000FFFF : 32'h0;
      n_vec++;
      if (io_rvalid !== 1'b1 || io_rdata !== exp) begin
        n_fail++; $display("FAIL post_reset_k%0d: rvalid=%b rdata=%h want 1/%h", k, io_rvalid, io_rdata, exp);
      end
    end
    io_rd = 1'b0;
    do_read(2'd3);
    n_vec++;
    if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_count: got %h want 00000000", io_rdata); end
    do_read(2'd2);
    n_vec++;
    if (io_rdata !== 32'h0) begin n_fail++; $display("FAIL post_reset_latch: got %h want 00000000", io_rdata); end
  endtask

  initial begin
    test_reset();
    test_switch();
    test_glitch();
    test_press();
    test_set_wins();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
